// File: rtl/cpu_seq_mc.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a sticky TRAP state.
// Owns PC, instruction register and retire counter; handshakes imem/dmem via ack.
module cpu_seq_mc #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = '0,
   parameter int unsigned     IMEM_TIMEOUT = 15,
   parameter bit              SKIP_MEM     = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            dmem_req,
   input  logic            dmem_ack,
   input  logic            is_mem_op,
   input  logic            illegal,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc,
   output logic [2:0]      state,
   output logic            rf_we,
   output logic            retire,
   output logic [31:0]     instret,
   output logic            fault,
   output logic [1:0]      fault_cause
);

   localparam logic [2:0] S_FETCH   = 3'b000;
   localparam logic [2:0] S_DECODE  = 3'b001;
   localparam logic [2:0] S_EXECUTE = 3'b010;
   localparam logic [2:0] S_MEM     = 3'b011;
   localparam logic [2:0] S_WB      = 3'b100;
   localparam logic [2:0] S_TRAP    = 3'b101;

   localparam logic [1:0] C_TIMEOUT  = 2'd1;
   localparam logic [1:0] C_ILLEGAL  = 2'd2;
   localparam logic [1:0] C_MISALIGN = 2'd3;

   // Last FETCH wait count that may still see an ack before the fetch is declared dead.
   localparam logic [7:0] TMO_LAST = 8'(IMEM_TIMEOUT - 1);

   logic [2:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] npc_q, npc_d;
   logic [31:0]     instr_q, instr_d;
   logic [31:0]     instret_q, instret_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [1:0]      cause_q, cause_d;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      npc_d     = npc_q;
      instr_d   = instr_q;
      instret_d = instret_q;
      cnt_d     = cnt_q;
      cause_d   = cause_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               cnt_d   = '0;
               state_d = S_DECODE;
            end else if (cnt_q == TMO_LAST) begin
               cause_d = C_TIMEOUT;
               state_d = S_TRAP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DECODE: begin
            if (illegal) begin
               cause_d = C_ILLEGAL;
               state_d = S_TRAP;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            // A misaligned redirect traps before next_pc is latched, so pc stays put.
            if (branch_taken && (branch_target[1:0] != 2'b00)) begin
               cause_d = C_MISALIGN;
               state_d = S_TRAP;
            end else begin
               npc_d   = branch_taken ? branch_target : pc_q + XLEN'(4);
               state_d = (is_mem_op || !SKIP_MEM) ? S_MEM : S_WB;
            end
         end
         S_MEM: begin
            if (!is_mem_op || dmem_ack) state_d = S_WB;
         end
         S_WB: begin
            pc_d      = npc_q;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         npc_q     <= RESET_PC;
         instr_q   <= '0;
         instret_q <= '0;
         cnt_q     <= '0;
         cause_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         npc_q     <= npc_d;
         instr_q   <= instr_d;
         instret_q <= instret_d;
         cnt_q     <= cnt_d;
         cause_q   <= cause_d;
      end
   end

   assign imem_req    = (state_q == S_FETCH);
   assign imem_addr   = pc_q;
   assign dmem_req    = (state_q == S_MEM) && is_mem_op;
   assign rf_we       = (state_q == S_WB);
   assign retire      = (state_q == S_WB);
   assign fault       = (state_q == S_TRAP);
   assign fault_cause = cause_q;
   assign instr       = instr_q;
   assign pc          = pc_q;
   assign state       = state_q;
   assign instret     = instret_q;

endmodule
